sample_mem_sched: RTL

- Per-audio-sample scheduler that shares one single-port sample BRAM (64K x 8) between three requesters: record writer, playback reader, and the echo delay-line writer/reader.
- Sits between the parameter selector outputs (record mode, song select, echo setting) and the audio datapath.
- Runs a fixed 5-cycle slot sequence per sample strobe, so every sample has deterministic latency.

---
 rtl/sample_mem_sched_pkg.sv | 31 +++
 rtl/echo_ring_ptr.sv | 44 ++++
 rtl/sample_mem_sched.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sample_mem_sched_pkg.sv
// -----------------------------------------------------------------------------
// sample_mem_sched_pkg
//   Shared definitions for the per-sample BRAM scheduler: default widths,
//   slot-sequence state encoding, echo ring base nibble and song clamp.
// -----------------------------------------------------------------------------
package sample_mem_sched_pkg;

  localparam int SAMPLE_W       = 8;   // default sample width
  localparam int SONG_POS_W     = 12;  // 4096 samples per song
  localparam int ECHO_DLY_SHIFT = 7;   // echo delay = echo_sel << 7 samples

  // Upper address nibble of the echo delay ring (0xC000-0xCFFF).
  localparam logic [3:0] ECHO_BASE = 4'hC;

  // Highest valid song slot; larger selections fold onto it.
  localparam logic [3:0] MAX_SONG = 4'd11;

  // Fixed five-step sequence run once per accepted sample strobe.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLOT0,  // song region access (record write / play read)
    ST_SLOT1,  // echo ring write
    ST_SLOT2,  // echo ring delayed read
    ST_CAP     // capture echo data, advance pointers
  } state_t;

  function automatic logic [3:0] clamp_song(input logic [3:0] song);
    return (song > MAX_SONG) ? MAX_SONG : song;
  endfunction

endpackage

// File: rtl/echo_ring_ptr.sv
// -----------------------------------------------------------------------------
// echo_ring_ptr
//   Write pointer of the echo delay ring plus the delayed read pointer.
//   The read pointer trails the write pointer by (echo_sel << ECHO_SHIFT)
//   samples; the subtraction wraps naturally at the POS_W-bit width, which
//   gives the modulo-ring behaviour.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset (pointer to 0)
//   advance   in   step the write pointer by one sample
//   echo_sel  in   echo setting, 0 = no delay
//   wr_ptr    out  current ring write pointer
//   rd_ptr    out  ring read pointer, wr_ptr - delay (mod ring size)
// -----------------------------------------------------------------------------
module echo_ring_ptr
  import sample_mem_sched_pkg::*;
#(
  parameter int POS_W      = SONG_POS_W,
  parameter int ECHO_SHIFT = ECHO_DLY_SHIFT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic [4:0]       echo_sel,
  output logic [POS_W-1:0] wr_ptr,
  output logic [POS_W-1:0] rd_ptr
);

  logic [POS_W-1:0] delay;

  // Delay in samples; truncation to POS_W keeps it inside the ring.
  assign delay  = POS_W'(echo_sel) << ECHO_SHIFT;
  assign rd_ptr = wr_ptr - delay;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (advance) begin
      wr_ptr <= wr_ptr + POS_W'(1);
    end
  end

endmodule

// File: rtl/sample_mem_sched.sv
// -----------------------------------------------------------------------------
// sample_mem_sched
//   Shares one single-port 64K x 8 sample BRAM between the record writer, the
//   playback reader and the echo delay line. Each accepted sample strobe runs
//   IDLE -> SLOT0 -> SLOT1 -> SLOT2 -> CAP -> IDLE, so latency is fixed:
//   strobe in cycle T, new play/echo samples with sample_valid in T+5.
//
// Ports:
//   clk              in   system clock
//   reset            in   synchronous, active-high reset
//   ready            in   one-cycle audio sample strobe
//   record_mode_sel  in   1 = record, 0 = play
//   song_name_sel    in   song slot 0-11 (larger values clamp to 11)
//   echo_sel         in   echo setting, 0 = echo off
//   mic_sample       in   sample to record
//   mix_sample       in   mixed output sample, written into the echo ring
//   mem_addr         out  BRAM address (registered)
//   mem_we           out  BRAM write enable (registered)
//   mem_din          out  BRAM write data (registered)
//   mem_dout         in   BRAM read data, one cycle after mem_addr
//   play_sample      out  playback sample
//   echo_sample      out  delayed echo sample
//   sample_valid     out  one-cycle pulse when play/echo samples update
//   overrun          out  sticky: a strobe arrived while a sequence was busy
// -----------------------------------------------------------------------------
module sample_mem_sched
  import sample_mem_sched_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int POS_W      = SONG_POS_W,
  parameter int ECHO_SHIFT = ECHO_DLY_SHIFT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ready,
  input  logic                record_mode_sel,
  input  logic [3:0]          song_name_sel,
  input  logic [4:0]          echo_sel,
  input  logic [DATA_W-1:0]   mic_sample,
  input  logic [DATA_W-1:0]   mix_sample,
  output logic [4+POS_W-1:0]  mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout,
  output logic [DATA_W-1:0]   play_sample,
  output logic [DATA_W-1:0]   echo_sample,
  output logic                sample_valid,
  output logic                overrun
);

  localparam int ADDR_W = 4 + POS_W;

  state_t state, state_next;

  // Per-sample snapshot. rec_q/song_q also serve as the "previous snapshot"
  // used to detect a mode or song change at the next strobe.
  logic              rec_q,       rec_next;
  logic [3:0]        song_q,      song_next;
  logic [4:0]        echo_sel_q,  echo_sel_next;
  logic [DATA_W-1:0] mix_q,       mix_next;

  logic [POS_W-1:0]  pos,         pos_next;
  logic [DATA_W-1:0] play_hold,   play_hold_next;

  logic [ADDR_W-1:0] addr_next;
  logic              we_next;
  logic [DATA_W-1:0] din_next;
  logic [DATA_W-1:0] play_next;
  logic [DATA_W-1:0] echo_sample_next;
  logic              valid_next;
  logic              overrun_next;

  logic              ring_advance;
  logic [POS_W-1:0]  ring_wr;
  logic [POS_W-1:0]  ring_rd;

  logic [3:0]        song_in;
  logic              mode_change;

  assign song_in     = clamp_song(song_name_sel);
  assign mode_change = (record_mode_sel != rec_q) || (song_in != song_q);

  echo_ring_ptr #(
    .POS_W      (POS_W),
    .ECHO_SHIFT (ECHO_SHIFT)
  ) u_echo_ring_ptr (
    .clk      (clk),
    .reset    (reset),
    .advance  (ring_advance),
    .echo_sel (echo_sel_q),
    .wr_ptr   (ring_wr),
    .rd_ptr   (ring_rd)
  );

  // Next-state logic. Each case arm prepares the bus values for the *next*
  // cycle, so the registered BRAM outputs line up with the named slot.
  always_comb begin
    // NOTE: every signal gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    state_next       = state;
    rec_next         = rec_q;
    song_next        = song_q;
    echo_sel_next    = echo_sel_q;
    mix_next         = mix_q;
    pos_next         = pos;
    play_hold_next   = play_hold;
    addr_next        = mem_addr;
    we_next          = 1'b0;
    din_next         = mem_din;
    play_next        = play_sample;
    echo_sample_next = echo_sample;
    valid_next       = 1'b0;
    ring_advance     = 1'b0;
    overrun_next     = overrun | (ready && (state != ST_IDLE));

    unique case (state)
      ST_IDLE: begin
        if (ready) begin
          state_next    = ST_SLOT0;
          rec_next      = record_mode_sel;
          song_next     = song_in;
          echo_sel_next = echo_sel;
          mix_next      = mix_sample;
          // A new mode or song restarts at the beginning of the song.
          pos_next      = mode_change ? '0 : pos;
          // SLOT0 bus: song region; din doubles as the mic snapshot.
          addr_next     = {song_in, pos_next};
          we_next       = record_mode_sel;
          din_next      = mic_sample;
        end
      end

      ST_SLOT0: begin
        state_next = ST_SLOT1;
        addr_next  = {ECHO_BASE, ring_wr};
        we_next    = 1'b1;
        din_next   = mix_q;
      end

      ST_SLOT1: begin
        state_next = ST_SLOT2;
        // Data for the SLOT0 song address arrives now.
        if (!rec_q) begin
          play_hold_next = mem_dout;
        end
        addr_next = {ECHO_BASE, ring_rd};
      end

      ST_SLOT2: begin
        state_next = ST_CAP;
      end

      ST_CAP: begin
        state_next       = ST_IDLE;
        play_next        = play_hold;
        // With echo off the SLOT2 read hit the sample just written; drop it.
        echo_sample_next = (echo_sel_q == '0) ? '0 : mem_dout;
        valid_next       = 1'b1;
        pos_next         = pos + POS_W'(1);
        ring_advance     = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      rec_q        <= 1'b1;
      song_q       <= '0;
      echo_sel_q   <= '0;
      mix_q        <= '0;
      pos          <= '0;
      play_hold    <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_din      <= '0;
      play_sample  <= '0;
      echo_sample  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_next;
      rec_q        <= rec_next;
      song_q       <= song_next;
      echo_sel_q   <= echo_sel_next;
      mix_q        <= mix_next;
      pos          <= pos_next;
      play_hold    <= play_hold_next;
      mem_addr     <= addr_next;
      mem_we       <= we_next;
      mem_din      <= din_next;
      play_sample  <= play_next;
      echo_sample  <= echo_sample_next;
      sample_valid <= valid_next;
      overrun      <= overrun_next;
    end
  end

endmodule
